// File: rtl/processor_mc.sv
`default_nettype none
// ============================================================================
//  Module   : processor_mc
//  Brief    : Multi-cycle RV32I core (FETCH/EXEC/MEM/WB) with valid-qualified
//             IMEM/DMEM handshakes, memory wait timeout and sticky halt.
//             Optional feature macro: PROCESSOR_MC_COUNTERS_EN (cycle/instret
//             counters readable through CSRRS).
//  Revision : 1.0 - initial release
// ============================================================================
module processor_mc #(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned TMO_W       = 8
) (
    input  logic        clk,
    input  logic        reset,
    output logic [31:0] op_inst_addr,
    output logic        op_inst_rd,
    input  logic        ip_inst_valid,
    input  logic [31:0] ip_inst_from_imem,
    output logic [31:0] op_data_addr,
    output logic        op_data_wr,
    output logic [3:0]  op_data_mask,
    output logic [31:0] op_data_from_proc,
    output logic        op_data_rd,
    input  logic        ip_data_valid,
    input  logic [31:0] ip_data_from_dmem,
    output logic        op_halt
);

    localparam logic [6:0]  c_OPC_LUI    = 7'b0110111;
    localparam logic [6:0]  c_OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0]  c_OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  c_OPC_JALR   = 7'b1100111;
    localparam logic [6:0]  c_OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  c_OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  c_OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  c_OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0]  c_OPC_OP     = 7'b0110011;
    localparam logic [6:0]  c_OPC_SYSTEM = 7'b1110011;
    localparam logic [31:0] c_NOP        = 32'h0000_0013;
    localparam bit          c_TMO_EN     = (MEM_TIMEOUT != 0);
    localparam logic [TMO_W-1:0] c_TMO_LAST =
        TMO_W'((MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_EXEC  = 2'd1,
        S_MEM   = 2'd2,
        S_WB    = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [31:0]       r_pc;
    logic [31:0]       r_ir;
    logic [31:0]       r_alur;
    logic [31:0]       r_npc;
    logic [31:0]       r_mdr;
    logic [TMO_W-1:0]  r_wait_cnt;
    logic              r_halt;
    logic [31:0]       r_regs [0:31];

    // ------------------------------------------------------------------
    // Decode, always from IR
    // ------------------------------------------------------------------
    logic [6:0]  w_opcode;
    logic [4:0]  w_rd;
    logic [4:0]  w_rs1_idx;
    logic [4:0]  w_rs2_idx;
    logic [2:0]  w_funct3;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_s;
    logic [31:0] w_imm_b;
    logic [31:0] w_imm_u;
    logic [31:0] w_imm_j;
    logic [31:0] w_rs1;
    logic [31:0] w_rs2;
    logic [31:0] w_pc_plus4;

    assign w_opcode   = r_ir[6:0];
    assign w_rd       = r_ir[11:7];
    assign w_funct3   = r_ir[14:12];
    assign w_rs1_idx  = r_ir[19:15];
    assign w_rs2_idx  = r_ir[24:20];
    assign w_imm_i    = {{20{r_ir[31]}}, r_ir[31:20]};
    assign w_imm_s    = {{20{r_ir[31]}}, r_ir[31:25], r_ir[11:7]};
    assign w_imm_b    = {{19{r_ir[31]}}, r_ir[31], r_ir[7], r_ir[30:25], r_ir[11:8], 1'b0};
    assign w_imm_u    = {r_ir[31:12], 12'h000};
    assign w_imm_j    = {{11{r_ir[31]}}, r_ir[31], r_ir[19:12], r_ir[20], r_ir[30:21], 1'b0};
    assign w_rs1      = (w_rs1_idx == 5'd0) ? 32'h0 : r_regs[w_rs1_idx];
    assign w_rs2      = (w_rs2_idx == 5'd0) ? 32'h0 : r_regs[w_rs2_idx];
    assign w_pc_plus4 = r_pc + 32'd4;

    // ------------------------------------------------------------------
    // ALU and branch comparator
    // ------------------------------------------------------------------
    logic [31:0] w_alu_b;
    logic [31:0] w_alu_out;
    logic        w_taken;

    assign w_alu_b = (w_opcode == c_OPC_OP) ? w_rs2 : w_imm_i;

    always_comb begin
        w_alu_out = 32'h0;
        case (w_funct3)
            // Bit 30 means SUB only for register-register ops; ADDI immediates reuse it
            3'b000: w_alu_out = ((w_opcode == c_OPC_OP) && r_ir[30]) ? (w_rs1 - w_alu_b)
                                                                   : (w_rs1 + w_alu_b);
            3'b001: w_alu_out = w_rs1 << w_alu_b[4:0];
            3'b010: w_alu_out = ($signed(w_rs1) < $signed(w_alu_b)) ? 32'd1 : 32'd0;
            3'b011: w_alu_out = (w_rs1 < w_alu_b) ? 32'd1 : 32'd0;
            3'b100: w_alu_out = w_rs1 ^ w_alu_b;
            3'b101: w_alu_out = r_ir[30] ? 32'($signed(w_rs1) >>> w_alu_b[4:0])
                                         : (w_rs1 >> w_alu_b[4:0]);
            3'b110: w_alu_out = w_rs1 | w_alu_b;
            default: w_alu_out = w_rs1 & w_alu_b;
        endcase
    end

    always_comb begin
        w_taken = 1'b0;
        case (w_funct3)
            3'b000:  w_taken = (w_rs1 == w_rs2);
            3'b001:  w_taken = (w_rs1 != w_rs2);
            3'b100:  w_taken = ($signed(w_rs1) <  $signed(w_rs2));
            3'b101:  w_taken = ($signed(w_rs1) >= $signed(w_rs2));
            3'b110:  w_taken = (w_rs1 <  w_rs2);
            3'b111:  w_taken = (w_rs1 >= w_rs2);
            default: w_taken = 1'b0;
        endcase
    end

`ifdef PROCESSOR_MC_COUNTERS_EN
    logic [63:0] r_cycle;
    logic [63:0] r_instret;
    logic [31:0] w_csr_val;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle   <= 64'h0;
            r_instret <= 64'h0;
        end else if (!r_halt) begin
            r_cycle <= r_cycle + 64'd1;
            if (r_state == S_WB) begin
                r_instret <= r_instret + 64'd1;
            end
        end
    end

    always_comb begin
        case (r_ir[31:20])
            12'hC00: w_csr_val = r_cycle[31:0];
            12'hC80: w_csr_val = r_cycle[63:32];
            12'hC02: w_csr_val = r_instret[31:0];
            12'hC82: w_csr_val = r_instret[63:32];
            default: w_csr_val = 32'h0;
        endcase
    end
`endif

    // ------------------------------------------------------------------
    // Per-opcode result, next PC and control
    // ------------------------------------------------------------------
    logic [31:0] w_result;
    logic [31:0] w_npc;
    logic        w_wr_en;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misaligned;

    always_comb begin
        w_result   = w_alu_out;
        w_npc      = w_pc_plus4;
        w_wr_en    = 1'b0;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        case (w_opcode)
            c_OPC_LUI:    begin w_result = w_imm_u;          w_wr_en = 1'b1; end
            c_OPC_AUIPC:  begin w_result = r_pc + w_imm_u;   w_wr_en = 1'b1; end
            c_OPC_JAL: begin
                w_result = w_pc_plus4;
                w_npc    = r_pc + w_imm_j;
                w_wr_en  = 1'b1;
            end
            c_OPC_JALR: begin
                w_result = w_pc_plus4;
                w_npc    = (w_rs1 + w_imm_i) & ~32'd1;
                w_wr_en  = 1'b1;
            end
            c_OPC_BRANCH: begin
                if (w_taken) begin
                    w_npc = r_pc + w_imm_b;
                end
            end
            c_OPC_LOAD: begin
                w_result  = w_rs1 + w_imm_i;
                w_is_load = 1'b1;
                w_wr_en   = 1'b1;
            end
            c_OPC_STORE: begin
                w_result   = w_rs1 + w_imm_s;
                w_is_store = 1'b1;
            end
            c_OPC_OPIMM, c_OPC_OP: w_wr_en = 1'b1;
`ifdef PROCESSOR_MC_COUNTERS_EN
            c_OPC_SYSTEM: begin
                if ((w_funct3 == 3'b010) && (w_rs1_idx == 5'd0)) begin
                    w_result = w_csr_val;
                    w_wr_en  = 1'b1;
                end
            end
`endif
            default: ;
        endcase
    end

    assign w_misaligned = (w_is_load || w_is_store) &&
                          (((w_funct3[1:0] == 2'b01) && w_result[0]) ||
                           ((w_funct3[1:0] == 2'b10) && (w_result[1:0] != 2'b00)));

    // ------------------------------------------------------------------
    // Load lane extraction and store lane formatting
    // ------------------------------------------------------------------
    logic [7:0]  w_lane_b;
    logic [15:0] w_lane_h;
    logic [31:0] w_load_val;

    assign w_lane_b = 8'(ip_data_from_dmem >> {r_alur[1:0], 3'b000});
    assign w_lane_h = r_alur[1] ? ip_data_from_dmem[31:16] : ip_data_from_dmem[15:0];

    always_comb begin
        case (w_funct3)
            3'b000:  w_load_val = {{24{w_lane_b[7]}}, w_lane_b};
            3'b001:  w_load_val = {{16{w_lane_h[15]}}, w_lane_h};
            3'b100:  w_load_val = {24'h0, w_lane_b};
            3'b101:  w_load_val = {16'h0, w_lane_h};
            default: w_load_val = ip_data_from_dmem;
        endcase
    end

    always_comb begin
        case (w_funct3[1:0])
            2'b00: begin
                op_data_mask      = 4'b0001 << r_alur[1:0];
                op_data_from_proc = {4{w_rs2[7:0]}};
            end
            2'b01: begin
                op_data_mask      = r_alur[1] ? 4'b1100 : 4'b0011;
                op_data_from_proc = {2{w_rs2[15:0]}};
            end
            default: begin
                op_data_mask      = 4'b1111;
                op_data_from_proc = w_rs2;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    logic w_waiting;
    logic w_wait_clr;
    logic w_tmo;
    logic w_halt_set;
    logic w_rf_we;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        op_inst_rd   = 1'b0;
        op_data_rd   = 1'b0;
        op_data_wr   = 1'b0;
        if (!r_halt) begin
            case (r_state)
                S_FETCH: begin
                    op_inst_rd = 1'b1;
                    if (ip_inst_valid) begin
                        w_next_state = S_EXEC;
                    end
                end
                S_EXEC: begin
                    // A misaligned access parks here with halt set
                    if (w_misaligned) begin
                        w_next_state = S_EXEC;
                    end else if (w_is_load || w_is_store) begin
                        w_next_state = S_MEM;
                    end else begin
                        w_next_state = S_WB;
                    end
                end
                S_MEM: begin
                    op_data_rd = w_is_load;
                    op_data_wr = w_is_store;
                    if (ip_data_valid) begin
                        w_next_state = S_WB;
                    end
                end
                default: w_next_state = S_FETCH;
            endcase
        end
    end

    assign w_waiting  = ((r_state == S_FETCH) && !ip_inst_valid) ||
                        ((r_state == S_MEM)   && !ip_data_valid);
    assign w_wait_clr = (w_next_state != r_state) &&
                        ((w_next_state == S_FETCH) || (w_next_state == S_MEM));
    assign w_tmo      = c_TMO_EN && w_waiting && (r_wait_cnt == c_TMO_LAST);
    assign w_halt_set = w_tmo || ((r_state == S_EXEC) && w_misaligned);
    assign w_rf_we    = (r_state == S_WB) && !r_halt && w_wr_en && (w_rd != 5'd0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc       <= RESET_PC;
            r_ir       <= c_NOP;
            r_alur     <= 32'h0;
            r_npc      <= RESET_PC;
            r_mdr      <= 32'h0;
            r_wait_cnt <= '0;
            r_halt     <= 1'b0;
        end else if (!r_halt) begin
            if (w_halt_set) begin
                r_halt <= 1'b1;
            end
            if (w_wait_clr) begin
                r_wait_cnt <= '0;
            end else if (w_waiting) begin
                r_wait_cnt <= r_wait_cnt + TMO_W'(1);
            end
            case (r_state)
                S_FETCH: if (ip_inst_valid) r_ir <= ip_inst_from_imem;
                S_EXEC: begin
                    r_alur <= w_result;
                    r_npc  <= w_npc;
                end
                S_MEM:   if (ip_data_valid) r_mdr <= w_load_val;
                default: r_pc <= r_npc;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_rf_we) begin
            r_regs[w_rd] <= w_is_load ? r_mdr : r_alur;
        end
    end

    assign op_inst_addr = r_pc;
    assign op_data_addr = r_alur;
    assign op_halt      = r_halt;

endmodule
`default_nettype wire
